auv_csr_file: RTL and testbench

Responder end of the CSR space bus. The CSR execution unit drives this bus as the initiator, and this block answers it. It holds the machine-mode CSRs of the single-hart RV32 core: status, trap setup/handling, scratch and 64-bit cycle/instret counters. It also takes trap-entry and mret events from the pipeline and drives interrupt-pending and trap-vector outputs back to it. An unimplemented address is signalled to the initiator by withholding cbus_ack.

---
 rtl/auv_csr_pkg.sv | 35 +++
 rtl/auv_csr_counter64.sv | 43 ++++
 rtl/auv_csr_file.sv | 202 ++++++++++++++++++++
 tb/tb_auv_csr_file.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/auv_csr_pkg.sv
// auv_csr_pkg
//   Shared constants for the machine-mode CSR responder: 12-bit CSR
//   addresses, mstatus bit positions, interrupt bit positions (common to
//   mie and mip) and the writable-bit mask of mie.
package auv_csr_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam int unsigned IRQ_SW    = 3;
  localparam int unsigned IRQ_TIMER = 7;
  localparam int unsigned IRQ_EXT   = 11;

  localparam logic [31:0] MIE_WMASK  = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/auv_csr_counter64.sv
// auv_csr_counter64
//   64-bit wrapping counter readable and writable as two 32-bit halves.
//   A write to either half replaces that half and suppresses the increment
//   for that cycle; the low-to-high carry is taken on the same edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   inc             count enable for this cycle
//   wr_lo, wr_hi    replace low / high half with wdata
//   wdata           write data
//   lo, hi          current counter halves
module auv_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign lo = cnt_q[31:0];
  assign hi = cnt_q[63:32];

endmodule

// File: rtl/auv_csr_file.sv
// auv_csr_file
//   Machine-mode CSR file of a single-hart RV32 core, answering the CSR
//   space bus as responder. Illegal accesses (unmapped address, or a write
//   into read-only space) are reported by withholding cbus_ack.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cbus_adr/_dat_wr         request address and (pre-merged) write data
//   cbus_rd/_wr              one-cycle read / write request
//   cbus_dat_rd, cbus_ack    registered read data and one-cycle ack
//   trap_en/_cause/_pc/_val  trap entry event and its CSR payload
//   mret, instret_inc        mret retire and instruction-retired pulses
//   irq_ext/_timer/_sw       level interrupt lines (form mip)
//   mtvec_o, mepc_o          current trap vector / exception PC
//   irq_pending              mstatus.MIE & |(mie & mip)
module auv_csr_file
  import auv_csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] HART_ID   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cbus_adr,
  input  logic [31:0] cbus_dat_wr,
  output logic [31:0] cbus_dat_rd,
  input  logic        cbus_rd,
  input  logic        cbus_wr,
  output logic        cbus_ack,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instret_inc,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending
);

  logic        ack_q, ack_d;
  logic [31:0] dat_rd_q, dat_rd_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [31:0] mip;
  logic [31:0] mstatus_rd;
  logic [31:0] rd_val;
  logic        addr_hit;
  logic        wr_legal, rd_legal;
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

  always_comb begin
    mip            = '0;
    mip[IRQ_SW]    = irq_sw;
    mip[IRQ_TIMER] = irq_timer;
    mip[IRQ_EXT]   = irq_ext;
  end

  // MPP is hardwired to machine mode on this single-privilege core.
  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[12:11]        = 2'b11;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
  end

  always_comb begin
    addr_hit = 1'b1;
    rd_val   = '0;
    case (cbus_adr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
      CSR_MHARTID:   rd_val = HART_ID;
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MISA:      rd_val = MISA_VAL;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MIP:       rd_val = mip;
      CSR_MCYCLE:    rd_val = cyc_lo;
      CSR_MCYCLEH:   rd_val = cyc_hi;
      CSR_MINSTRET:  rd_val = ins_lo;
      CSR_MINSTRETH: rd_val = ins_hi;
      default:       addr_hit = 1'b0;
    endcase
  end

  // A write wins over a simultaneous read; the read is dropped entirely.
  assign wr_legal = cbus_wr & addr_hit & (cbus_adr[11:10] != 2'b11);
  assign rd_legal = cbus_rd & ~cbus_wr & addr_hit;

  // Read data is held across writes and illegal reads: the initiator builds
  // set/clear write data from the last value it read.
  assign ack_d    = wr_legal | rd_legal;
  assign dat_rd_d = rd_legal ? rd_val : dat_rd_q;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (wr_legal) begin
      case (cbus_adr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = cbus_dat_wr[MSTATUS_MIE];
          mstatus_mpie_d = cbus_dat_wr[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = cbus_dat_wr & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = cbus_dat_wr & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = cbus_dat_wr;
        CSR_MEPC:     mepc_d     = cbus_dat_wr & ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = cbus_dat_wr;
        CSR_MTVAL:    mtval_d    = cbus_dat_wr;
        default: ;
      endcase
    end

    // Pipeline events override any same-cycle bus write (which is still acked).
    if (trap_en) begin
      mepc_d         = trap_pc & ALIGN_MASK;
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q          <= 1'b0;
      dat_rd_q       <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST & ALIGN_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      ack_q          <= ack_d;
      dat_rd_q       <= dat_rd_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  auv_csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_legal & (cbus_adr == CSR_MCYCLE)),
    .wr_hi (wr_legal & (cbus_adr == CSR_MCYCLEH)),
    .wdata (cbus_dat_wr),
    .lo    (cyc_lo),
    .hi    (cyc_hi)
  );

  auv_csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .wr_lo (wr_legal & (cbus_adr == CSR_MINSTRET)),
    .wr_hi (wr_legal & (cbus_adr == CSR_MINSTRETH)),
    .wdata (cbus_dat_wr),
    .lo    (ins_lo),
    .hi    (ins_hi)
  );

  assign cbus_ack    = ack_q;
  assign cbus_dat_rd = dat_rd_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_mie_q & |(mie_q & mip);

endmodule

// File: tb/tb_auv_csr_file.sv
// tb_auv_csr_file
//   Directed scenarios followed by randomized bus/event traffic, all checked
//   against a cycle-level reference model of the machine-mode CSR space.
module tb_auv_csr_file;

  localparam logic [31:0] TB_MISA  = 32'h4000_0100;
  localparam logic [31:0] TB_HART  = 32'h0000_0003;
  localparam logic [31:0] TB_MTVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cbus_adr;
  logic [31:0] cbus_dat_wr;
  logic [31:0] cbus_dat_rd;
  logic        cbus_rd, cbus_wr, cbus_ack;
  logic        trap_en;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        mret, instret_inc;
  logic        irq_ext, irq_timer, irq_sw;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending;

  auv_csr_file #(
    .MISA_VAL  (TB_MISA),
    .HART_ID   (TB_HART),
    .MTVEC_RST (TB_MTVEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cbus_adr    (cbus_adr),
    .cbus_dat_wr (cbus_dat_wr),
    .cbus_dat_rd (cbus_dat_rd),
    .cbus_rd     (cbus_rd),
    .cbus_wr     (cbus_wr),
    .cbus_ack    (cbus_ack),
    .trap_en     (trap_en),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_val    (trap_val),
    .mret        (mret),
    .instret_inc (instret_inc),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .irq_sw      (irq_sw),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_reg   [bit [11:0]];
  logic [31:0] m_wmask [bit [11:0]];
  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_rd;

  task automatic m_reset();
    m_mie  = 0;
    m_mpie = 0;
    m_reg.delete();
    m_reg[12'h304] = 32'h0;
    m_reg[12'h305] = TB_MTVEC;
    m_reg[12'h340] = 32'h0;
    m_reg[12'h341] = 32'h0;
    m_reg[12'h342] = 32'h0;
    m_reg[12'h343] = 32'h0;
    m_wmask[12'h304] = 32'h0000_0888;
    m_wmask[12'h305] = 32'hFFFF_FFFC;
    m_wmask[12'h340] = 32'hFFFF_FFFF;
    m_wmask[12'h341] = 32'hFFFF_FFFC;
    m_wmask[12'h342] = 32'hFFFF_FFFF;
    m_wmask[12'h343] = 32'hFFFF_FFFF;
    m_cyc = 0;
    m_ins = 0;
    m_rd  = 0;
  endtask

  function automatic bit m_in_map(bit [11:0] a);
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_mip();
    return (32'(irq_sw) << 3) | (32'(irq_timer) << 7) | (32'(irq_ext) << 11);
  endfunction

  function automatic logic [31:0] m_read(bit [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return TB_MISA;
      12'h344: return m_mip();
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF14: return TB_HART;
      default: return m_reg.exists(a) ? m_reg[a] : 32'h0;
    endcase
  endfunction

  // One clock: apply the current inputs to the model, advance, then compare.
  task automatic step();
    bit [11:0]   a;
    logic [31:0] d;
    bit          wl, rl, exp_ack, old_mie, old_mpie, exp_irq;
    a  = cbus_adr;
    d  = cbus_dat_wr;
    wl = cbus_wr && m_in_map(a) && (a[11:10] != 2'b11);
    rl = !cbus_wr && cbus_rd && m_in_map(a);
    exp_ack  = wl || rl;
    old_mie  = m_mie;
    old_mpie = m_mpie;
    if (rl) m_rd = m_read(a);

    if (wl && a == 12'hB00)      m_cyc[31:0]  = d;
    else if (wl && a == 12'hB80) m_cyc[63:32] = d;
    else                         m_cyc        = m_cyc + 1;
    if (wl && a == 12'hB02)      m_ins[31:0]  = d;
    else if (wl && a == 12'hB82) m_ins[63:32] = d;
    else if (instret_inc)        m_ins        = m_ins + 1;

    if (wl && m_reg.exists(a)) m_reg[a] = d & m_wmask[a];
    if (wl && a == 12'h300) begin
      m_mie  = d[3];
      m_mpie = d[7];
    end
    if (trap_en) begin
      m_reg[12'h341] = trap_pc & 32'hFFFF_FFFC;
      m_reg[12'h342] = trap_cause;
      m_reg[12'h343] = trap_val;
      m_mpie = old_mie;
      m_mie  = 0;
    end else if (mret) begin
      m_mie  = old_mpie;
      m_mpie = 1;
    end

    @(negedge clk);
    exp_irq = m_mie && ((m_reg[12'h304] & m_mip()) != 0);
    check_val("ack",         cbus_ack,    exp_ack);
    check_val("dat_rd",      cbus_dat_rd, m_rd);
    check_val("mtvec_o",     mtvec_o,     m_reg[12'h305]);
    check_val("mepc_o",      mepc_o,      m_reg[12'h341]);
    check_val("irq_pending", irq_pending, exp_irq);
  endtask

  task automatic bus(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d);
    cbus_rd = rd; cbus_wr = wr; cbus_adr = a; cbus_dat_wr = d;
    step();
    cbus_rd = 0; cbus_wr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [11:0] pool [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                             12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                             12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0,
                             12'h345, 12'hB01, 12'hC00};

  initial begin
    rst = 1; cbus_adr = 0; cbus_dat_wr = 0; cbus_rd = 0; cbus_wr = 0;
    trap_en = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0;
    instret_inc = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    check_val("rst_ack",   cbus_ack,    1'b0);
    check_val("rst_rd",    cbus_dat_rd, 32'h0);
    check_val("rst_mtvec", mtvec_o,     TB_MTVEC);
    check_val("rst_mepc",  mepc_o,      32'h0);
    check_val("rst_irq",   irq_pending, 1'b0);
    rst = 0;

    bus(1, 0, 12'h300, 0);
    check_val("mstatus_rst", cbus_dat_rd, 32'h0000_1800);
    check_val("mstatus_ack", cbus_ack, 1'b1);
    idle(1);
    check_val("ack_pulse", cbus_ack, 1'b0);

    bus(0, 1, 12'h340, 32'hDEAD_BEEF);
    check_val("mscratch_wr_ack", cbus_ack, 1'b1);
    bus(1, 0, 12'h340, 0);
    check_val("mscratch_rd", cbus_dat_rd, 32'hDEAD_BEEF);

    bus(1, 0, 12'h7C0, 0);
    check_val("illegal_rd_ack", cbus_ack, 1'b0);
    check_val("illegal_rd_hold", cbus_dat_rd, 32'hDEAD_BEEF);

    bus(0, 1, 12'hF14, 32'h1234_5678);
    check_val("ro_wr_ack", cbus_ack, 1'b0);
    bus(1, 0, 12'hF14, 0);
    check_val("mhartid", cbus_dat_rd, TB_HART);

    bus(1, 1, 12'h340, 32'h0000_0055);
    check_val("rdwr_hold", cbus_dat_rd, TB_HART);

    bus(0, 1, 12'h304, 32'hFFFF_FFFF);
    bus(1, 0, 12'h304, 0);
    check_val("mie_mask", cbus_dat_rd, 32'h0000_0888);

    bus(0, 1, 12'h300, 32'h0000_0008);
    trap_en = 1; trap_pc = 32'h0000_1236; trap_cause = 32'h8000_000B; trap_val = 32'hABCD;
    step();
    trap_en = 0;
    check_val("trap_mepc", mepc_o, 32'h0000_1234);
    bus(1, 0, 12'h342, 0);
    check_val("trap_mcause", cbus_dat_rd, 32'h8000_000B);
    bus(1, 0, 12'h300, 0);
    check_val("trap_mstatus", cbus_dat_rd, 32'h0000_1880);
    mret = 1;
    step();
    mret = 0;
    bus(1, 0, 12'h300, 0);
    check_val("mret_mstatus", cbus_dat_rd, 32'h0000_1888);

    irq_timer = 1;
    step();
    check_val("irq_timer_pend", irq_pending, 1'b1);
    irq_timer = 0;

    bus(0, 1, 12'hB00, 32'hFFFF_FFFF);
    bus(0, 1, 12'hB80, 32'h0);
    idle(2);
    bus(1, 0, 12'hB80, 0);
    check_val("mcycleh_carry", cbus_dat_rd, 32'h1);
    bus(1, 0, 12'hB00, 0);
    check_val("mcycle_small", cbus_dat_rd < 32'd8, 1'b1);

    // Reset while an ack is in flight must clear it at once.
    cbus_rd = 1; cbus_adr = 12'h300;
    @(posedge clk); #1;
    check_val("pre_rst_ack", cbus_ack, 1'b1);
    cbus_rd = 0;
    rst = 1;
    #1;
    check_val("mid_rst_ack", cbus_ack, 1'b0);
    check_val("mid_rst_rd", cbus_dat_rd, 32'h0);
    @(negedge clk);
    rst = 0;
    m_reset();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cbus_adr = pool[$urandom_range(0, 20)];
      cbus_dat_wr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      cbus_rd = ($urandom_range(0, 2) != 0);
      cbus_wr = ($urandom_range(0, 2) == 0);
      trap_en = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
      mret = ($urandom_range(0, 15) == 0);
      instret_inc = $urandom_range(0, 1);
      irq_ext = $urandom_range(0, 1);
      irq_timer = $urandom_range(0, 1);
      irq_sw = $urandom_range(0, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
